// File: rtl/nes_clk_enable_gen.sv
// PLL-lock qualifier and NES master/PPU/CPU clock-enable generator on clk_sys.
// Optional lock-loss counter output enabled by defining NES_CLKGEN_LOCKLOSS_CNT_EN.
//
// state  | meaning
// IDLE   | no synchronized lock; core held in reset, enables off
// WAIT   | lock present; counting LOCK_WAIT stable cycles before release
// RUN    | core released; clock enables running
module nes_clk_enable_gen #(
    parameter int LOCK_WAIT    = 1024,
    parameter int SYS_DIV      = 4,
    parameter int PPU_DIV_NTSC = 4,
    parameter int PPU_DIV_PAL  = 5,
    parameter int CPU_DIV_NTSC = 12,
    parameter int CPU_DIV_PAL  = 16
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       pll_locked,
    input  logic       pal_mode,
    input  logic       soft_reset,
    output logic       core_reset_n,
    output logic       master_ce,
    output logic       ppu_ce,
    output logic       cpu_ce,
    output logic [3:0] cpu_phase
`ifdef NES_CLKGEN_LOCKLOSS_CNT_EN
    ,
    output logic [7:0] lockloss_count
`endif
);

    localparam int HOLD_W = $clog2(LOCK_WAIT);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LOCK_WAIT - 1);
    localparam logic [3:0] SYS_LAST      = 4'(SYS_DIV - 1);
    localparam logic [3:0] PPU_LAST_NTSC = 4'(PPU_DIV_NTSC - 1);
    localparam logic [3:0] PPU_LAST_PAL  = 4'(PPU_DIV_PAL - 1);
    localparam logic [3:0] CPU_LAST_NTSC = 4'(CPU_DIV_NTSC - 1);
    localparam logic [3:0] CPU_LAST_PAL  = 4'(CPU_DIV_PAL - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WAIT = 2'b01,
        S_RUN  = 2'b10
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_lock_meta;
    logic                r_lock_s;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic                r_pal_q;
    logic [3:0]          r_sys_cnt;
    logic [3:0]          r_ppu_cnt;
    logic [3:0]          r_cpu_cnt;
    logic                r_master_ce;
    logic                r_ppu_ce;
    logic                r_cpu_ce;
    logic                w_run_stay;
    logic                w_tick;
    logic [3:0]          w_ppu_last;
    logic [3:0]          w_cpu_last;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
        end else begin
            r_lock_meta <= pll_locked;
            r_lock_s    <= r_lock_meta;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Lock loss outranks soft_reset, which outranks the hold terminal count.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (r_lock_s) w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (!r_lock_s)                    w_state_nxt = S_IDLE;
                else if (soft_reset)              w_state_nxt = S_WAIT;
                else if (r_hold_cnt == HOLD_LAST) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (!r_lock_s)       w_state_nxt = S_IDLE;
                else if (soft_reset) w_state_nxt = S_WAIT;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)
            r_hold_cnt <= '0;
        else if (r_state != S_WAIT || w_state_nxt != S_WAIT || soft_reset)
            r_hold_cnt <= '0;
        else
            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)
            r_pal_q <= 1'b0;
        else if (r_state == S_WAIT && w_state_nxt == S_RUN)
            r_pal_q <= pal_mode;
    end

    // Gating on the next state keeps every enable low from the first cycle after RUN exits.
    assign w_run_stay = (r_state == S_RUN) && (w_state_nxt == S_RUN);
    assign w_tick     = w_run_stay && (r_sys_cnt == SYS_LAST);
    assign w_ppu_last = r_pal_q ? PPU_LAST_PAL : PPU_LAST_NTSC;
    assign w_cpu_last = r_pal_q ? CPU_LAST_PAL : CPU_LAST_NTSC;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_sys_cnt <= '0;
        end else if (!w_run_stay || r_sys_cnt == SYS_LAST) begin
            r_sys_cnt <= '0;
        end else begin
            r_sys_cnt <= r_sys_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_ppu_cnt <= '0;
            r_cpu_cnt <= '0;
        end else if (!w_run_stay) begin
            r_ppu_cnt <= '0;
            r_cpu_cnt <= '0;
        end else if (w_tick) begin
            r_ppu_cnt <= (r_ppu_cnt == w_ppu_last) ? 4'd0 : r_ppu_cnt + 4'd1;
            r_cpu_cnt <= (r_cpu_cnt == w_cpu_last) ? 4'd0 : r_cpu_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_master_ce <= 1'b0;
            r_ppu_ce    <= 1'b0;
            r_cpu_ce    <= 1'b0;
        end else begin
            r_master_ce <= w_tick;
            r_ppu_ce    <= w_tick && (r_ppu_cnt == w_ppu_last);
            r_cpu_ce    <= w_tick && (r_cpu_cnt == w_cpu_last);
        end
    end

    assign core_reset_n = (r_state == S_RUN);
    assign master_ce    = r_master_ce;
    assign ppu_ce       = r_ppu_ce;
    assign cpu_ce       = r_cpu_ce;
    assign cpu_phase    = r_cpu_cnt;

`ifdef NES_CLKGEN_LOCKLOSS_CNT_EN
    logic [7:0] r_lockloss_cnt;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)
            r_lockloss_cnt <= '0;
        else if (r_state == S_RUN && !r_lock_s && r_lockloss_cnt != 8'hFF)
            r_lockloss_cnt <= r_lockloss_cnt + 8'd1;
    end

    assign lockloss_count = r_lockloss_cnt;
`endif

endmodule

// File: doc/nes_clk_enable_gen.md
Name: nes_clk_enable_gen

Overview:
Sits directly downstream of the core PLL. Runs on the 85.909 MHz system clock (4x NES master clock) and qualifies the PLL lock signal. Holds the NES core in reset until lock has been stable, then generates single-cycle master, PPU and CPU clock enables for the NTSC or PAL divide ratios. Any loss of lock, or a soft reset, re-enters the hold sequence.

Parameters:
LOCK_WAIT, 1024, clk_sys cycles of continuous synchronized lock required before core_reset_n is released; legal range is 2 or more.
SYS_DIV, 4, clk_sys cycles per master_ce.
PPU_DIV_NTSC, 4, master_ce pulses per ppu_ce in NTSC mode.
PPU_DIV_PAL, 5, master_ce pulses per ppu_ce in PAL mode.
CPU_DIV_NTSC, 12, master_ce pulses per cpu_ce in NTSC mode.
CPU_DIV_PAL, 16, master_ce pulses per cpu_ce in PAL mode.

Ports:
clk_sys  in  1  85.909 MHz system clock (PLL outclk_0).
reset_n  in  1  asynchronous active-low reset.
pll_locked  in  1  PLL locked flag; asynchronous to clk_sys.
pal_mode  in  1  1 = PAL divide ratios; sampled only on entry to RUN.
soft_reset  in  1  synchronous request to re-hold the core.
core_reset_n  out  1  active-low reset to the NES core.
master_ce  out  1  one-cycle pulse every SYS_DIV clk_sys cycles.
ppu_ce  out  1  PPU clock enable; only ever high together with master_ce.
cpu_ce  out  1  CPU clock enable; only ever high together with master_ce.
cpu_phase  out  4  master-tick index within the current CPU cycle, 0..CPU_DIV-1.

Behaviour:
- Clock and reset: single clock, clk_sys. reset_n is asynchronous and active-low.
- reset_n low: all outputs are 0, state is IDLE, and all counters and synchronizer flops are 0.
- pll_locked synchronization: passes through a 2-flop synchronizer; the output is lock_s.
- State IDLE: core_reset_n=0, all enables 0. Moves to WAIT on the next edge where lock_s=1.
- State WAIT:
  - Hold counter starts at 0 and increments every cycle.
  - lock_s=0 -> IDLE, counter cleared.
  - soft_reset=1 -> counter cleared, stay in WAIT.
  - Counter == LOCK_WAIT-1 -> RUN; pal_mode is latched into pal_q on the same edge.
- State RUN: core_reset_n=1, taken directly from the state register (no extra delay).
  - lock_s=0 -> IDLE.
  - Otherwise soft_reset=1 -> WAIT with counter cleared.
  - Lock loss has priority over soft_reset.
  - On leaving RUN, core_reset_n and all enables are 0 from the next cycle.
- Lock latency: core_reset_n rises on the (LOCK_WAIT+3)th rising edge after pll_locked rises, provided pll_locked stays high.
- sys_cnt (0..SYS_DIV-1):
  - Held at 0 outside RUN; increments in RUN and wraps.
  - master_ce is registered, high for the one cycle following sys_cnt==SYS_DIV-1.
  - First master_ce occurs SYS_DIV cycles after core_reset_n rises.
- ppu_cnt and cpu_cnt:
  - Advance only on master_ce; both are held at 0 outside RUN.
  - ppu_ce pulses on every PPU_DIV-th master_ce; first pulse on the PPU_DIV-th.
  - cpu_ce pulses on every CPU_DIV-th master_ce; first pulse on the CPU_DIV-th.
  - PPU_DIV and CPU_DIV are selected by pal_q.
- cpu_phase: equals cpu_cnt. Reads 0 after the master_ce that carries cpu_ce. Updates only on master_ce.
- Coincidence: in NTSC mode, every cpu_ce coincides with a ppu_ce. Both coincide with master_ce.
- Mode change: a pal_mode change while in RUN has no effect until the next WAIT->RUN transition.
- Widths:
  - Hold counter is $clog2(LOCK_WAIT) bits.
  - Divider counters are 4 bits; all DIV parameters must be 16 or less.
- Lock glitches: a pll_locked glitch shorter than one clk_sys cycle may be missed. Any glitch captured by the synchronizer is treated as lock loss.

Optional Feature:
NES_CLKGEN_LOCKLOSS_CNT_EN
- Defined: adds output port lockloss_count, 8 bits.
  - Increments on each RUN->IDLE transition caused by lock_s=0.
  - Saturates at 255.
  - Cleared only by reset_n; soft_reset does not clear it.
- Not defined: the port, the counter and the logic are absent. All other behaviour is identical.

Test Plan:
- LOCK_WAIT=16, reset_n released, pll_locked held 1 -> core_reset_n rises on edge 19. master_ce, ppu_ce and cpu_ce are 0 before that edge.
- NTSC, 48 clk_sys cycles after release -> 12 master_ce, 3 ppu_ce, 1 cpu_ce. cpu_ce falls on the same cycle as the 12th master_ce and the 3rd ppu_ce. cpu_phase reads 11 immediately before that cycle and 0 after it.
- pal_mode=1 at entry to RUN, 64 cycles -> 16 master_ce, 3 ppu_ce (on master ticks 5, 10, 15), 1 cpu_ce on master tick 16. Toggling pal_mode mid-RUN leaves the ratios unchanged.
- pll_locked dropped for 5 cycles during RUN -> core_reset_n=0 three edges after the fall, enables stop. On re-lock, core_reset_n returns LOCK_WAIT+3 edges after the rise. lockloss_count goes 0->1 with the feature enabled.
- soft_reset pulsed 1 cycle in RUN -> core_reset_n low for exactly LOCK_WAIT cycles. soft_reset repeated mid-WAIT restarts the full LOCK_WAIT hold.
- reset_n asserted mid-RUN, asynchronously -> all outputs 0 immediately, without waiting for a clock edge. lockloss_count returns to 0.
